// File: rtl/touch_pkg.sv
// Shared types, defaults and helpers for the touch-point conditioning path.
package touch_pkg;

    localparam int unsigned COORD_W   = 16;
    localparam int unsigned H_ACT_DEF = 1024;
    localparam int unsigned V_ACT_DEF = 600;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_PRESSED
    } tp_state_e;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } point_t;

    function automatic logic [2*COORD_W-1:0] pack_xy(coord_t x, coord_t y);
        return {x, y};
    endfunction

    function automatic point_t unpack_xy(logic [2*COORD_W-1:0] w);
        point_t p;
        p.x = w[2*COORD_W-1:COORD_W];
        p.y = w[COORD_W-1:0];
        return p;
    endfunction

    // Clamp to [0,vmax] first, then optionally mirror about the clamped range.
    function automatic coord_t clamp_axis(coord_t v, coord_t vmax, logic mirror);
        coord_t c;
        c = (v > vmax) ? vmax : v;
        return mirror ? coord_t'(vmax - c) : c;
    endfunction

endpackage

// File: rtl/touch_point_conditioner_if.sv
// Report input and conditioned-point output bundle of the touch conditioner.
interface touch_point_conditioner_if;
    import touch_pkg::*;

    logic                   rpt_valid;
    logic                   rpt_touch;
    coord_t                 rpt_x;
    coord_t                 rpt_y;
    logic [2*COORD_W-1:0]   data_out;
    logic                   touch_active;
    logic                   press_pulse;
    logic                   release_pulse;

    modport master (
        output rpt_valid, rpt_touch, rpt_x, rpt_y,
        input  data_out, touch_active, press_pulse, release_pulse
    );

    modport slave (
        input  rpt_valid, rpt_touch, rpt_x, rpt_y,
        output data_out, touch_active, press_pulse, release_pulse
    );

endinterface

// File: rtl/touch_avg_buf.sv
// Sliding window of 2**AVG_LOG2 samples with preload and a running sum.
module touch_avg_buf
    import touch_pkg::*;
#(
    parameter int unsigned AVG_LOG2 = 2
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   load_i,
    input  logic   shift_i,
    input  coord_t sample_i,
    output coord_t avg_o
);

    localparam int unsigned DEPTH = 1 << AVG_LOG2;
    localparam int unsigned SUM_W = COORD_W + AVG_LOG2;

    coord_t             win_q [DEPTH];
    logic [SUM_W-1:0]   sum_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) win_q[i] <= '0;
            sum_q <= '0;
        end else if (load_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) win_q[i] <= sample_i;
            sum_q <= SUM_W'(sample_i) << AVG_LOG2;
        end else if (shift_i) begin
            win_q[0] <= sample_i;
            for (int unsigned i = 1; i < DEPTH; i++) win_q[i] <= win_q[i-1];
            // Add the newcomer, drop the sample falling off the end.
            sum_q <= sum_q + SUM_W'(sample_i) - SUM_W'(win_q[DEPTH-1]);
        end
    end

    assign avg_o = coord_t'(sum_q >> AVG_LOG2);

endmodule

// File: rtl/touch_point_conditioner.sv
// Touch report conditioner: transform/clamp, press debounce, window average and
// release timeout, with a fixed three-cycle pipeline from report to data_out.
module touch_point_conditioner
    import touch_pkg::*;
#(
    parameter int unsigned H_ACT       = H_ACT_DEF,
    parameter int unsigned V_ACT       = V_ACT_DEF,
    parameter int unsigned PRESS_CNT   = 3,
    parameter int unsigned AVG_LOG2    = 2,
    parameter int unsigned TIMEOUT_CYC = 5_000_000,
    parameter bit          SWAP_XY     = 1'b0,
    parameter bit          MIRROR_X    = 1'b0,
    parameter bit          MIRROR_Y    = 1'b0
) (
    input  logic                      clk,
    input  logic                      reset,
    touch_point_conditioner_if.slave  tp_if
);

    localparam coord_t      X_MAX = coord_t'(H_ACT - 1);
    localparam coord_t      Y_MAX = coord_t'(V_ACT - 1);
    localparam int unsigned TMO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned CNT_W = $clog2(PRESS_CNT + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYC);

    coord_t             sw_x, sw_y;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               s1_valid_q, s1_touch_q, s1_tmo_q;
    coord_t             s1_x_q, s1_y_q;
    tp_state_e          state_q;
    logic [CNT_W-1:0]   cnt_q, cnt_inc;
    logic               press_ev_q, release_ev_q;
    logic               touch_rpt, buf_load, buf_shift;
    coord_t             avg_x, avg_y;
    logic [2*COORD_W-1:0] data_out_q;
    logic               touch_active_q, press_pulse_q, release_pulse_q;

    always_comb begin
        sw_x  = SWAP_XY ? tp_if.rpt_y : tp_if.rpt_x;
        sw_y  = SWAP_XY ? tp_if.rpt_x : tp_if.rpt_y;
        tmo_d = tmo_q;
        if (tp_if.rpt_valid)     tmo_d = '0;
        else if (tmo_q != TMO_MAX) tmo_d = tmo_q + TMO_W'(1);
    end

    // Expiry rides the stage-1 pipe so a report arriving on the expiry cycle wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_touch_q <= 1'b0;
            s1_tmo_q   <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            tmo_q      <= '0;
        end else begin
            s1_valid_q <= tp_if.rpt_valid;
            s1_touch_q <= tp_if.rpt_touch;
            s1_tmo_q   <= !tp_if.rpt_valid && (tmo_d == TMO_MAX);
            s1_x_q     <= clamp_axis(sw_x, X_MAX, MIRROR_X);
            s1_y_q     <= clamp_axis(sw_y, Y_MAX, MIRROR_Y);
            tmo_q      <= tmo_d;
        end
    end

    assign touch_rpt = s1_valid_q && s1_touch_q;
    assign buf_load  = touch_rpt && (state_q == ST_IDLE);
    assign buf_shift = touch_rpt && (state_q != ST_IDLE);
    assign cnt_inc   = cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            press_ev_q   <= 1'b0;
            release_ev_q <= 1'b0;
        end else begin
            press_ev_q   <= 1'b0;
            release_ev_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (touch_rpt) begin
                        cnt_q <= CNT_W'(1);
                        if (PRESS_CNT == 1) begin
                            state_q    <= ST_PRESSED;
                            press_ev_q <= 1'b1;
                        end else begin
                            state_q <= ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (touch_rpt) begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == CNT_W'(PRESS_CNT)) begin
                            state_q    <= ST_PRESSED;
                            press_ev_q <= 1'b1;
                        end
                    end else if (s1_valid_q || s1_tmo_q) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_PRESSED: begin
                    if ((s1_valid_q && !s1_touch_q) || (!s1_valid_q && s1_tmo_q)) begin
                        state_q      <= ST_IDLE;
                        release_ev_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    touch_avg_buf #(.AVG_LOG2(AVG_LOG2)) u_avg_x (
        .clk      (clk),
        .reset    (reset),
        .load_i   (buf_load),
        .shift_i  (buf_shift),
        .sample_i (s1_x_q),
        .avg_o    (avg_x)
    );

    touch_avg_buf #(.AVG_LOG2(AVG_LOG2)) u_avg_y (
        .clk      (clk),
        .reset    (reset),
        .load_i   (buf_load),
        .shift_i  (buf_shift),
        .sample_i (s1_y_q),
        .avg_o    (avg_y)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out_q      <= '0;
            touch_active_q  <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
        end else begin
            data_out_q      <= (state_q == ST_PRESSED) ? pack_xy(avg_x, avg_y) : '0;
            touch_active_q  <= (state_q == ST_PRESSED);
            press_pulse_q   <= press_ev_q;
            release_pulse_q <= release_ev_q;
        end
    end

    assign tp_if.data_out      = data_out_q;
    assign tp_if.touch_active  = touch_active_q;
    assign tp_if.press_pulse   = press_pulse_q;
    assign tp_if.release_pulse = release_pulse_q;

endmodule
